// File: rtl/regfile_pkg.sv
// Shared command/state encodings and default geometry for the
// accumulator register file and its clear sequencer.
package regfile_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_PW = 4;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACCW = 3'd1,
    CMD_SET  = 3'd2,
    CMD_GET  = 3'd3,
    CMD_SWAP = 3'd4,
    CMD_CLR  = 3'd5
  } cmd_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Codes 6 and 7 have no meaning and are rejected in every state.
  function automatic logic is_illegal_cmd(input logic [2:0] c);
    return (c > 3'd5);
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks idx from 0 to NREG-1, one register per edge,
// with registered busy/done flags.
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int PW = DEF_PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [PW-1:0] o_idx
);

  state_t        r_state;
  logic [PW-1:0] r_idx;
  logic          r_busy;
  logic          r_done;

  // Sequencer FSM with registered busy/done; reset aborts a sequence silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= {PW{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= ST_CLEAR;
            r_idx   <= {PW{1'b0}};
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (r_idx == {PW{1'b1}}) begin
            r_state <= ST_IDLE;
            r_idx   <= {PW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + {{(PW-1){1'b0}}, 1'b1};
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= {PW{1'b0}};
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_idx  = r_idx;

endmodule

// File: rtl/acc_reg_file_v2.sv
// Accumulator-centred register file: register 0 is the accumulator, the
// others are reached through op_addr; a sequencer can clear the whole array.
module acc_reg_file_v2
  import regfile_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int PW = DEF_PW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    cmd,
  input  logic [DW-1:0] wdata,
  input  logic [PW-1:0] op_addr,
  output logic [DW-1:0] acc_data,
  output logic [DW-1:0] op_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int NREG = 2**PW;

  logic [DW-1:0] r_regs [NREG];
  logic          r_err;
  logic          w_busy;
  logic          w_done;
  logic [PW-1:0] w_idx;
  logic          w_start;
  logic          w_op_nz;
  logic          w_reject;

  assign w_start  = (cmd == CMD_CLR) && !w_busy;
  assign w_op_nz  = (op_addr != {PW{1'b0}});
  assign w_reject = is_illegal_cmd(cmd) || (w_busy && (cmd != CMD_NOP));

  rf_clear_seq #(.PW(PW)) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_idx   (w_idx)
  );

  // Register array: sequencer clear has priority; commands only act while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {DW{1'b0}};
      end
    end else if (w_busy) begin
      r_regs[w_idx] <= {DW{1'b0}};
    end else begin
      case (cmd)
        CMD_ACCW: r_regs[0] <= wdata;
        CMD_SET:  if (w_op_nz) r_regs[op_addr] <= r_regs[0];
        CMD_GET:  if (w_op_nz) r_regs[0] <= r_regs[op_addr];
        CMD_SWAP: begin
          if (w_op_nz) begin
            r_regs[0]       <= r_regs[op_addr];
            r_regs[op_addr] <= r_regs[0];
          end
        end
        default: ;
      endcase
    end
  end

  // Rejected-command flag, pulses the cycle after the offending command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_reject;
    end
  end

  assign acc_data = r_regs[0];
  assign op_data  = r_regs[op_addr];
  assign busy     = w_busy;
  assign done     = w_done;
  assign err      = r_err;

endmodule

// File: tb/tb_acc_reg_file_v2.sv
// Directed self-checking bench for acc_reg_file_v2 (DW=8, PW=4).
module tb_acc_reg_file_v2;
  import regfile_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] cmd;
  logic [7:0] wdata;
  logic [3:0] op_addr;
  logic [7:0] acc_data;
  logic [7:0] op_data;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;
  int busy_cycles;
  int done_cnt;
  int err_cnt;

  acc_reg_file_v2 #(.DW(8), .PW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmd),
    .wdata    (wdata),
    .op_addr  (op_addr),
    .acc_data (acc_data),
    .op_data  (op_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] c, input logic [7:0] w, input logic [3:0] a);
    cmd = c; wdata = w; op_addr = a;
    @(posedge clk); #1;
    cmd = CMD_NOP;
  endtask

  task automatic rd(input logic [3:0] a, input string tag, input logic [7:0] exp);
    op_addr = a; #1;
    chk(tag, 32'(op_data), 32'(exp));
  endtask

  function automatic logic [7:0] pv(input int k);
    return (k == 0) ? 8'h01 : 8'(8'hA0 + k);
  endfunction

  initial begin
    reset = 1'b1; cmd = CMD_NOP; wdata = 8'h00; op_addr = 4'd0;
    #3;
    chk("rst_acc",  32'(acc_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err",  32'(err), 32'h0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;

    // ACCW then SET to reg3
    cyc(CMD_ACCW, 8'h5A, 4'd0);
    cyc(CMD_SET,  8'h00, 4'd3);
    chk("set_acc", 32'(acc_data), 32'h5A);
    rd(4'd3, "set_r3", 8'h5A);
    chk("set_err", 32'(err), 32'h0);
    for (int k = 1; k < 16; k++) begin
      if (k != 3) rd(4'(k), "set_other", 8'h00);
    end

    // SWAP reg0=11 with reg7=22
    cyc(CMD_ACCW, 8'h22, 4'd0);
    cyc(CMD_SET,  8'h00, 4'd7);
    cyc(CMD_ACCW, 8'h11, 4'd0);
    cyc(CMD_SWAP, 8'h00, 4'd7);
    chk("swap_acc", 32'(acc_data), 32'h22);
    rd(4'd7, "swap_r7", 8'h11);

    // GET reg3 into accumulator
    cyc(CMD_GET, 8'h00, 4'd3);
    chk("get_acc", 32'(acc_data), 32'h5A);

    // illegal codes and GET op_addr=0
    cyc(CMD_ACCW, 8'h33, 4'd0);
    cyc(3'd6, 8'hEE, 4'd7);
    chk("ill6_err", 32'(err), 32'h1);
    chk("ill6_acc", 32'(acc_data), 32'h33);
    rd(4'd7, "ill6_r7", 8'h11);
    rd(4'd3, "ill6_r3", 8'h5A);
    cyc(CMD_NOP, 8'h00, 4'd0);
    chk("ill6_err_clr", 32'(err), 32'h0);
    cyc(3'd7, 8'hEE, 4'd3);
    chk("ill7_err", 32'(err), 32'h1);
    chk("ill7_acc", 32'(acc_data), 32'h33);
    cyc(CMD_GET, 8'h00, 4'd0);
    chk("get0_err", 32'(err), 32'h0);
    chk("get0_acc", 32'(acc_data), 32'h33);
    cyc(CMD_SWAP, 8'h00, 4'd0);
    chk("swap0_acc", 32'(acc_data), 32'h33);
    chk("swap0_err", 32'(err), 32'h0);

    // full clear with distinct contents
    for (int k = 1; k < 16; k++) begin
      cyc(CMD_ACCW, pv(k), 4'd0);
      cyc(CMD_SET, 8'h00, 4'(k));
    end
    cyc(CMD_ACCW, pv(0), 4'd0);
    cyc(CMD_CLR, 8'h00, 4'd0);
    chk("clr_acc_hold", 32'(acc_data), 32'(pv(0)));
    busy_cycles = 0; done_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      chk("clr_busy", 32'(busy), 32'((c >= 1) && (c <= 16)));
      chk("clr_done", 32'(done), 32'(c == 17));
      if (c >= 2 && c <= 17) rd(4'(c - 2), "clr_zero", 8'h00);
      if (c <= 16) rd(4'(c - 1), "clr_pending", pv(c - 1));
      @(posedge clk); #1;
    end
    chk("clr_busy_len", 32'(busy_cycles), 32'd16);
    chk("clr_done_cnt", 32'(done_cnt), 32'd1);
    for (int k = 0; k < 16; k++) rd(4'(k), "clr_all0", 8'h00);

    // commands rejected during clear
    cyc(CMD_ACCW, 8'h77, 4'd0);
    cyc(CMD_CLR, 8'h00, 4'd0);
    busy_cycles = 0; err_cnt = 0; done_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (busy) busy_cycles++;
      if (err) err_cnt++;
      if (done) done_cnt++;
      chk("rej_err", 32'(err), 32'((c == 4) || (c == 7)));
      chk("rej_done", 32'(done), 32'(c == 17));
      cmd = (c == 3) ? CMD_ACCW : ((c == 6) ? CMD_CLR : CMD_NOP);
      wdata = 8'hFF;
      @(posedge clk); #1;
      cmd = CMD_NOP;
    end
    chk("rej_busy_len", 32'(busy_cycles), 32'd16);
    chk("rej_err_cnt", 32'(err_cnt), 32'd2);
    chk("rej_done_cnt", 32'(done_cnt), 32'd1);
    chk("rej_acc", 32'(acc_data), 32'h0);

    // async reset during clear
    cyc(CMD_ACCW, 8'h5C, 4'd0);
    cyc(CMD_SET, 8'h00, 4'd9);
    cyc(CMD_CLR, 8'h00, 4'd9);
    repeat (4) begin @(posedge clk); #1; end
    chk("ar_busy_pre", 32'(busy), 32'h1);
    rd(4'd9, "ar_r9_pre", 8'h5C);
    #1 reset = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_done", 32'(done), 32'h0);
    chk("ar_err",  32'(err), 32'h0);
    chk("ar_acc",  32'(acc_data), 32'h0);
    chk("ar_r9",   32'(op_data), 32'h0);
    @(posedge clk); #3;
    reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) done_cnt++;
      @(posedge clk); #1;
    end
    chk("ar_no_done", 32'(done_cnt), 32'd0);
    cyc(CMD_ACCW, 8'hA5, 4'd0);
    chk("ar_accw", 32'(acc_data), 32'hA5);

    // first command right after reset release
    #1 reset = 1'b1;
    @(posedge clk); #3;
    reset = 1'b0;
    cyc(CMD_ACCW, 8'h3C, 4'd0);
    chk("post_rst_accw", 32'(acc_data), 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_reg_file_v2.md
ACC_REG_FILE_V2 -- requirements
Module: acc_reg_file_v2

Interface
REQ-001 Parameter DW, default 8: data width of every register.
REQ-002 Parameter PW, default 4: operand pointer width; NREG = 2**PW registers, register 0 is the accumulator.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd  input  3  command code (regfile_pkg cmd_t): NOP=0, ACCW=1, SET=2, GET=3, SWAP=4, CLR=5; codes 6-7 illegal.
REQ-006 wdata  input  DW  data written to accumulator by ACCW.
REQ-007 op_addr  input  PW  operand register pointer for SET/GET/SWAP and op_data.
REQ-008 acc_data  output  DW  combinational read of register 0.
REQ-009 op_data  output  DW  combinational read of register[op_addr].
REQ-010 busy  output  1  high while the clear sequencer runs.
REQ-011 done  output  1  one-cycle pulse when a clear sequence completes.
REQ-012 err  output  1  one-cycle pulse when a command is rejected.

Function
REQ-013 In IDLE, exactly one command executes per edge: ACCW reg0<=wdata; SET reg[op_addr]<=reg0; GET reg0<=reg[op_addr]; SWAP reg0 and reg[op_addr] exchange atomically on one edge.
REQ-014 SET, GET or SWAP with op_addr=0 leaves all registers unchanged and is not an error.
REQ-015 NOP changes no register; register contents hold indefinitely otherwise.
REQ-016 Reads are combinational: write results are visible on acc_data/op_data in the cycle after the edge, with no bypass of the same-cycle write.
REQ-017 FSM states (regfile_pkg state_t): IDLE, CLEAR.
REQ-018 CLR sampled in IDLE moves the FSM to CLEAR, sets index idx=0, asserts busy from the next cycle; no register is modified on that edge.
REQ-019 In CLEAR, each edge writes reg[idx]<=0 and increments idx; clearing order is 0 to NREG-1.
REQ-020 On the edge that clears reg[NREG-1], the FSM returns to IDLE, busy deasserts and done is high for exactly that following cycle; busy is high for exactly NREG cycles.
REQ-021 During CLEAR every non-NOP cmd (including CLR) is ignored and produces an err pulse the following cycle; NOP is silent.
REQ-022 Illegal codes 6-7 in any state change no state and produce an err pulse the following cycle.
REQ-023 op_data during CLEAR reflects partially cleared contents (already-cleared indices read 0).
REQ-024 idx is PW bits wide; no wrap beyond NREG-1 occurs because CLEAR exits at that index.
REQ-025 done and err are registered; both never assert in the same cycle except on a rejected command coinciding with the final clear edge, in which case both pulse.

Reset
REQ-026 reset asserted forces, without waiting for clk, all NREG registers to 0, FSM to IDLE, idx to 0, busy, done, err to 0.
REQ-027 reset asserted mid-CLEAR aborts the sequence; no done pulse is generated.
REQ-028 The first command is accepted on the first rising clk edge after reset deasserts.

Structure
REQ-029 Package regfile_pkg holds cmd_t, state_t, and default DW/PW constants.
REQ-030 The clear sequencer (FSM, idx, busy, done) is one sub-module, rf_clear_seq; register array and command decode remain in acc_reg_file_v2.
REQ-031 Register storage is a flat array of NREG words of DW bits; no memory macro.

Verification (DW=8, PW=4)
REQ-032 Reset; ACCW wdata=8'h5A; SET op_addr=3 -> acc_data=8'h5A and op_data(addr 3)=8'h5A; other registers read 0.
REQ-033 reg0=8'h11, reg7=8'h22; SWAP op_addr=7 -> next cycle acc_data=8'h22, op_data(addr 7)=8'h11.
REQ-034 Load distinct nonzero values in all 16 registers; CLR -> busy high exactly 16 cycles, reg[k] reads 0 from cycle k+2 after CLR edge, done pulses once, all registers 0.
REQ-035 During CLEAR issue ACCW wdata=8'hFF and CLR -> err pulses once per command, acc_data stays 0 after done, sequence length unchanged at 16.
REQ-036 cmd=3'd6 with reg0=8'h33 -> err pulses one cycle, all registers unchanged; GET op_addr=0 -> no change, no err.
REQ-037 Assert reset asynchronously at cycle 5 of CLEAR -> all outputs 0 immediately, no done pulse, ACCW wdata=8'hA5 after release reads 8'hA5.
